// File: rtl/qwb_pkg.sv
// Shared width helpers for the Q-table write-back unit.
package qwb_pkg;

   function automatic int unsigned calc_n_level(int unsigned l_width);
      return 32'd1 << (l_width / 2);
   endfunction

   function automatic int unsigned calc_d_width(int unsigned l_width, int unsigned q_width);
      return q_width * calc_n_level(l_width);
   endfunction

   function automatic int unsigned calc_wen_width(int unsigned l_width, int unsigned q_width);
      return calc_d_width(l_width, q_width) / 8;
   endfunction

   function automatic int unsigned calc_addr_shift(int unsigned l_width, int unsigned q_width);
      return $clog2(calc_wen_width(l_width, q_width));
   endfunction

   function automatic int unsigned calc_road_w(int unsigned n_road);
      return (n_road < 3) ? 1 : $clog2(n_road);
   endfunction

endpackage

// File: rtl/qwb_merge.sv
// Replaces one Q level of a row and produces that level's byte enables.
module qwb_merge #(
   parameter int unsigned Q_WIDTH = 16,
   parameter int unsigned DUR_W   = 2,
   localparam int unsigned N_LEVEL   = 1 << DUR_W,
   localparam int unsigned D_WIDTH   = Q_WIDTH * N_LEVEL,
   localparam int unsigned WEN_WIDTH = D_WIDTH / 8,
   localparam int unsigned Q_BYTES   = Q_WIDTH / 8
) (
   input  logic [D_WIDTH-1:0]   row_in,
   input  logic [DUR_W-1:0]     dur,
   input  logic [Q_WIDTH-1:0]   q,
   output logic [D_WIDTH-1:0]   row_out,
   output logic [WEN_WIDTH-1:0] ben
);

   always_comb begin
      row_out = row_in;
      ben     = '0;
      for (int unsigned l = 0; l < N_LEVEL; l++) begin
         if (DUR_W'(l) == dur) begin
            row_out[l*Q_WIDTH +: Q_WIDTH] = q;
            ben[l*Q_BYTES +: Q_BYTES]     = '1;
         end
      end
   end

endmodule

// File: rtl/qtable_wb_unit.sv
// Q-table write-back pipeline: BRAM row capture, level merge, per-road byte enables.
// Define QWB_FWD_EN to patch in-flight rows with each committed Q value.
module qtable_wb_unit
   import qwb_pkg::*;
#(
   parameter int unsigned L_WIDTH    = 4,
   parameter int unsigned Q_WIDTH    = 16,
   parameter int unsigned N_ROAD     = 4,
   parameter int unsigned PIPE_DEPTH = 5,
   parameter int unsigned ADDR_WIDTH = 32,
   localparam int unsigned S_WIDTH    = 2 * L_WIDTH,
   localparam int unsigned D_WIDTH    = calc_d_width(L_WIDTH, Q_WIDTH),
   localparam int unsigned WEN_WIDTH  = calc_wen_width(L_WIDTH, Q_WIDTH),
   localparam int unsigned ADDR_SHIFT = calc_addr_shift(L_WIDTH, Q_WIDTH),
   localparam int unsigned ROAD_W     = calc_road_w(N_ROAD),
   localparam int unsigned DUR_W      = L_WIDTH / 2,
   localparam int unsigned A_WIDTH    = ROAD_W + DUR_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [S_WIDTH-1:0]            S,
   input  logic [A_WIDTH-1:0]            A,
   input  logic [N_ROAD*D_WIDTH-1:0]     rd_data,
   input  logic [Q_WIDTH-1:0]            Q_new,
   input  logic                          wen,
   output logic [ADDR_WIDTH-1:0]         rd_addr,
   output logic                          wr_valid,
   output logic [ADDR_WIDTH-1:0]         wr_addr,
   output logic [D_WIDTH-1:0]            wr_data,
   output logic [N_ROAD*WEN_WIDTH-1:0]   wen_bram,
   output logic                          err_road
);

   localparam int unsigned NSTG = PIPE_DEPTH - 1;

   typedef struct packed {
      logic               valid;
      logic [S_WIDTH-1:0] state;
      logic [ROAD_W-1:0]  road;
      logic [DUR_W-1:0]   dur;
      logic [D_WIDTH-1:0] row;
   } entry_t;

   entry_t                  stg_q   [NSTG];
   entry_t                  stg_d   [NSTG];
   logic [D_WIDTH-1:0]      eff_row [NSTG];
   logic [D_WIDTH-1:0]      rd_row;
   logic [D_WIDTH-1:0]      cm_row;
   logic [WEN_WIDTH-1:0]    cm_ben;
   logic [ROAD_W-1:0]       a_road;
   logic [DUR_W-1:0]        a_dur;
   logic                    road_ok;
   logic                    commit;
   logic [N_ROAD*WEN_WIDTH-1:0] wen_bram_d;

   assign a_road  = A[A_WIDTH-1 -: ROAD_W];
   assign a_dur   = A[DUR_W-1:0];
   assign road_ok = 32'(a_road) < N_ROAD;
   assign commit  = stg_q[NSTG-1].valid & wen;
   assign rd_addr = ADDR_WIDTH'(S) << ADDR_SHIFT;

   always_comb begin
      rd_row = '0;
      for (int unsigned r = 0; r < N_ROAD; r++) begin
         if (stg_q[0].road == ROAD_W'(r)) rd_row = rd_data[r*D_WIDTH +: D_WIDTH];
      end
   end

   // Stage 0 has no row yet; its row is whatever the BRAM returns this cycle.
   always_comb begin
      eff_row[0] = rd_row;
      for (int unsigned k = 1; k < NSTG; k++) eff_row[k] = stg_q[k].row;
   end

`ifdef QWB_FWD_EN
   logic [D_WIDTH-1:0]   mrg_row [NSTG];
   logic [WEN_WIDTH-1:0] mrg_ben [NSTG];

   // The last stage's merge doubles as the commit merge.
   for (genvar k = 0; k < NSTG; k++) begin : g_fwd
      qwb_merge #(.Q_WIDTH(Q_WIDTH), .DUR_W(DUR_W)) u_merge (
         .row_in  (eff_row[k]),
         .dur     (stg_q[NSTG-1].dur),
         .q       (Q_new),
         .row_out (mrg_row[k]),
         .ben     (mrg_ben[k])
      );
   end
   assign cm_row = mrg_row[NSTG-1];
   assign cm_ben = mrg_ben[NSTG-1];
`else
   qwb_merge #(.Q_WIDTH(Q_WIDTH), .DUR_W(DUR_W)) u_merge (
      .row_in  (eff_row[NSTG-1]),
      .dur     (stg_q[NSTG-1].dur),
      .q       (Q_new),
      .row_out (cm_row),
      .ben     (cm_ben)
   );
`endif

   always_comb begin
      stg_d[0] = '{valid: in_valid & road_ok, state: S, road: a_road, dur: a_dur, row: '0};
      for (int unsigned k = 1; k < NSTG; k++) begin
         stg_d[k]     = stg_q[k-1];
         stg_d[k].row = eff_row[k-1];
`ifdef QWB_FWD_EN
         if (commit && stg_q[k-1].valid && stg_q[k-1].state == stg_q[NSTG-1].state &&
             stg_q[k-1].road == stg_q[NSTG-1].road) begin
            for (int unsigned b = 0; b < WEN_WIDTH; b++) begin
               if (mrg_ben[k-1][b]) stg_d[k].row[b*8 +: 8] = mrg_row[k-1][b*8 +: 8];
            end
         end
`endif
      end
   end

   always_comb begin
      wen_bram_d = '0;
      for (int unsigned r = 0; r < N_ROAD; r++) begin
         if (commit && stg_q[NSTG-1].road == ROAD_W'(r)) begin
            wen_bram_d[r*WEN_WIDTH +: WEN_WIDTH] = cm_ben;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < NSTG; k++) stg_q[k].valid <= 1'b0;
         wr_valid <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         wen_bram <= '0;
         err_road <= 1'b0;
      end else begin
         stg_q    <= stg_d;
         wr_valid <= commit;
         wen_bram <= wen_bram_d;
         if (commit) begin
            wr_addr <= ADDR_WIDTH'(stg_q[NSTG-1].state) << ADDR_SHIFT;
            wr_data <= cm_row;
         end
         if (in_valid && !road_ok) err_road <= 1'b1;
      end
   end

endmodule
